// File: rtl/mlaccel_pkg.sv
// Shared widths, return-tag types and address-range helper for the ML accelerator memory.
// Latency: none (types only). Backpressure: n/a.
package mlaccel_pkg;

    localparam int unsigned MLACCEL_WORD_W = 64;
    localparam int unsigned MLACCEL_ADDR_W = 16;
    localparam int unsigned MLACCEL_STRB_W = 8;

    typedef enum logic {
        OWN_COMP = 1'b0,
        OWN_HOST = 1'b1
    } owner_e;

    typedef struct packed {
        logic   vld;
        owner_e owner;
        logic   oor;
    } ret_tag_t;

    function automatic logic addr_oor(input logic [MLACCEL_ADDR_W-1:0] addr,
                                      input int unsigned words);
        return {16'b0, addr} >= words;
    endfunction

endpackage

// File: rtl/mlaccel_memory_if.sv
// Compute memory port plus host request/return channel of the ML accelerator memory.
// Latency: n/a. Backpressure: host_ready throttles host; compute is never stalled.
interface mlaccel_memory_if;
    import mlaccel_pkg::*;

    logic                      comp_ren;
    logic [MLACCEL_STRB_W-1:0] comp_wen;
    logic [MLACCEL_ADDR_W-1:0] comp_addr;
    logic [MLACCEL_WORD_W-1:0] comp_wdata;
    logic [MLACCEL_WORD_W-1:0] comp_rdata;

    logic                      host_valid;
    logic                      host_ready;
    logic                      host_write;
    logic [MLACCEL_STRB_W-1:0] host_wstrb;
    logic [MLACCEL_ADDR_W-1:0] host_addr;
    logic [MLACCEL_WORD_W-1:0] host_wdata;
    logic                      host_rvalid;
    logic [MLACCEL_WORD_W-1:0] host_rdata;

    logic                      err;

    modport master (
        output comp_ren, comp_wen, comp_addr, comp_wdata,
        output host_valid, host_write, host_wstrb, host_addr, host_wdata,
        input  comp_rdata, host_ready, host_rvalid, host_rdata, err
    );

    modport slave (
        input  comp_ren, comp_wen, comp_addr, comp_wdata,
        input  host_valid, host_write, host_wstrb, host_addr, host_wdata,
        output comp_rdata, host_ready, host_rvalid, host_rdata, err
    );

endinterface

// File: rtl/mlaccel_memory_ram.sv
// Single-port byte-writable RAM, synchronous read-first, no arbitration.
// Latency: 1 cycle read. Backpressure: none.
module mlaccel_memory_ram
    import mlaccel_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 4096,
    parameter int unsigned AW        = 12
) (
    input  logic                      clock_i,
    input  logic                      re_i,
    input  logic [MLACCEL_STRB_W-1:0] we_i,
    input  logic [AW-1:0]             addr_i,
    input  logic [MLACCEL_WORD_W-1:0] wdata_i,
    output logic [MLACCEL_WORD_W-1:0] rdata_o
);

    logic [MLACCEL_WORD_W-1:0] mem_q [MEM_WORDS];
    logic [MLACCEL_WORD_W-1:0] rdata_q;

    always_ff @(posedge clock_i) begin
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
        for (int k = 0; k < int'(MLACCEL_STRB_W); k++) begin
            if (we_i[k]) begin
                mem_q[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mlaccel_memory.sv
// Arbitrates compute (priority) and host onto one RAM port; tagged return pipeline and hold registers.
// Latency: RD_LATENCY cycles request-to-data. Backpressure: host_ready low whenever compute is active.
module mlaccel_memory
    import mlaccel_pkg::*;
#(
    parameter int unsigned MEM_WORDS  = 4096,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic           clock,
    input  logic           resetn,
    mlaccel_memory_if.slave bus
);

    localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    logic [1:0]                rdy_sync_q;
    logic                      comp_act;
    logic                      host_ready;
    logic                      host_acc;

    logic                      ram_re;
    logic [MLACCEL_STRB_W-1:0] ram_we;
    logic [MLACCEL_ADDR_W-1:0] sel_addr;
    logic [MLACCEL_WORD_W-1:0] ram_wdata;
    logic [MLACCEL_WORD_W-1:0] ram_rdata;
    logic                      sel_oor;

    ret_tag_t                  tag_d;
    ret_tag_t                  tag_q [RD_LATENCY];
    ret_tag_t                  ret_tag;
    logic [MLACCEL_WORD_W-1:0] ret_dat;
    logic [MLACCEL_WORD_W-1:0] ret_word;
    logic                      comp_ret;
    logic                      host_ret;

    logic [MLACCEL_WORD_W-1:0] hold_q, hold_d;
    logic                      err_q, err_d;

    // Host acceptance is held off until reset release has been synchronised.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rdy_sync_q <= 2'b00;
        end else begin
            rdy_sync_q <= {rdy_sync_q[0], 1'b1};
        end
    end

    assign comp_act       = bus.comp_ren | (|bus.comp_wen);
    assign host_ready     = rdy_sync_q[1] & ~comp_act;
    assign host_acc       = bus.host_valid & host_ready;
    assign bus.host_ready = host_ready;

    always_comb begin
        ram_re    = 1'b0;
        ram_we    = '0;
        sel_addr  = '0;
        ram_wdata = '0;
        sel_oor   = 1'b0;
        tag_d     = '{vld: 1'b0, owner: OWN_COMP, oor: 1'b0};
        if (comp_act) begin
            sel_addr  = bus.comp_addr;
            ram_wdata = bus.comp_wdata;
            ram_re    = bus.comp_ren;
            ram_we    = bus.comp_wen;
            tag_d.vld = bus.comp_ren;
        end else if (host_acc) begin
            sel_addr    = bus.host_addr;
            ram_wdata   = bus.host_wdata;
            ram_re      = ~bus.host_write;
            ram_we      = bus.host_write ? bus.host_wstrb : '0;
            tag_d.vld   = ~bus.host_write;
            tag_d.owner = OWN_HOST;
        end
        // Out-of-range writes are dropped; reads are zeroed at the pipeline exit.
        sel_oor   = addr_oor(sel_addr, MEM_WORDS);
        tag_d.oor = sel_oor;
        if (sel_oor) begin
            ram_we = '0;
        end
    end

    mlaccel_memory_ram #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_ram (
        .clock_i (clock),
        .re_i    (ram_re),
        .we_i    (ram_we),
        .addr_i  (sel_addr[AW-1:0]),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= tag_d;
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign ret_tag = tag_q[RD_LATENCY-1];

    // RAM output is stage 0; extra latency is added as plain data stages.
    generate
        if (RD_LATENCY == 1) begin : g_dat_direct
            assign ret_dat = ram_rdata;
        end else begin : g_dat_delay
            logic [MLACCEL_WORD_W-1:0] dly_q [RD_LATENCY-1];
            always_ff @(posedge clock) begin
                dly_q[0] <= ram_rdata;
                for (int i = 1; i < int'(RD_LATENCY) - 1; i++) begin
                    dly_q[i] <= dly_q[i-1];
                end
            end
            assign ret_dat = dly_q[RD_LATENCY-2];
        end
    endgenerate

    assign ret_word = ret_tag.oor ? '0 : ret_dat;
    assign comp_ret = ret_tag.vld & (ret_tag.owner == OWN_COMP);
    assign host_ret = ret_tag.vld & (ret_tag.owner == OWN_HOST);

    assign hold_d = comp_ret ? ret_word : hold_q;
    assign err_d  = err_q | (bus.comp_ren & (|bus.comp_wen));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hold_q <= '0;
            err_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            err_q  <= err_d;
        end
    end

    assign bus.comp_rdata  = hold_d;
    assign bus.host_rvalid = host_ret;
    assign bus.host_rdata  = host_ret ? ret_word : '0;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_mlaccel_memory.sv
// Directed bench for mlaccel_memory with a due-cycle scoreboard and a reference memory model.
module tb_mlaccel_memory;

    localparam int unsigned MW  = 4096;
    localparam int unsigned RDL = 2;

    typedef struct {
        int          due;
        bit          is_host;
        logic [63:0] dat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mlaccel_memory_if bus();

    mlaccel_memory #(
        .MEM_WORDS  (MW),
        .RD_LATENCY (RDL)
    ) dut (
        .clock  (clk),
        .resetn (rst_n),
        .bus    (bus)
    );

    exp_t        exp_q[$];
    logic [63:0] mem_m [int];
    logic [63:0] hold_m;
    bit          err_m;
    int          cyc, rs_cnt;
    int          n_chk, n_pass, n_fail;
    bit          acc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] rd_m(input logic [15:0] a);
        int ai = int'(a);
        if (ai >= int'(MW)) return 64'h0;
        return mem_m.exists(ai) ? mem_m[ai] : 64'hx;
    endfunction

    task automatic wr_m(input logic [15:0] a, input logic [7:0] wen, input logic [63:0] wd);
        int ai = int'(a);
        logic [63:0] v;
        if (ai >= int'(MW)) return;
        v = mem_m.exists(ai) ? mem_m[ai] : 64'hx;
        for (int k = 0; k < 8; k++) begin
            if (wen[k]) v[8*k +: 8] = wd[8*k +: 8];
        end
        mem_m[ai] = v;
    endtask

    task automatic check_ret();
        exp_t e;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            if (e.is_host) begin
                chk("host_rvalid", 64'(bus.host_rvalid), 64'h1);
                chk("host_rdata", bus.host_rdata, e.dat);
            end else begin
                hold_m = e.dat;
                chk("host_rvalid_idle", 64'(bus.host_rvalid), 64'h0);
            end
        end else begin
            chk("host_rvalid_idle", 64'(bus.host_rvalid), 64'h0);
        end
        chk("comp_rdata", bus.comp_rdata, hold_m);
        chk("err", 64'(bus.err), 64'(err_m));
    endtask

    task automatic step();
        @(posedge clk);
        rs_cnt = rst_n ? ((rs_cnt < 2) ? rs_cnt + 1 : 2) : 0;
        #1;
        cyc++;
        check_ret();
    endtask

    task automatic cyc_drv(input logic cren, input logic [7:0] cwen, input logic [15:0] caddr,
                           input logic [63:0] cwd, input logic hv, input logic hw,
                           input logic [7:0] hs, input logic [15:0] ha, input logic [63:0] hwd,
                           output bit accepted);
        bit ract, rdy_e;
        bus.comp_ren   = cren;
        bus.comp_wen   = cwen;
        bus.comp_addr  = caddr;
        bus.comp_wdata = cwd;
        bus.host_valid = hv;
        bus.host_write = hw;
        bus.host_wstrb = hs;
        bus.host_addr  = ha;
        bus.host_wdata = hwd;
        #1;
        ract  = cren | (|cwen);
        rdy_e = (rs_cnt >= 2) && !ract;
        chk("host_ready", 64'(bus.host_ready), 64'(rdy_e));
        accepted = hv && rdy_e;
        if (ract) begin
            if (cren) exp_q.push_back('{cyc + int'(RDL), 1'b0, rd_m(caddr)});
            if (cren && (|cwen)) err_m = 1'b1;
            wr_m(caddr, cwen, cwd);
        end else if (accepted) begin
            if (!hw) exp_q.push_back('{cyc + int'(RDL), 1'b1, rd_m(ha)});
            else     wr_m(ha, hs, hwd);
        end
        step();
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) cyc_drv(0, 8'h0, 16'h0, 64'h0, 0, 0, 8'h0, 16'h0, 64'h0, a);
    endtask

    task automatic host_req(input logic w, input logic [7:0] s, input logic [15:0] a, input logic [63:0] wd);
        bit a_ok = 1'b0;
        for (int i = 0; i < 16 && !a_ok; i++) cyc_drv(0, 8'h0, 16'h0, 64'h0, 1, w, s, a, wd, a_ok);
        chk("host_accept_timeout", 64'(a_ok), 64'h1);
    endtask

    task automatic comp_wr(input logic [15:0] a, input logic [7:0] wen, input logic [63:0] wd);
        bit a_unused;
        cyc_drv(0, wen, a, wd, 0, 0, 8'h0, 16'h0, 64'h0, a_unused);
    endtask

    task automatic comp_rd(input logic [15:0] a);
        bit a_unused;
        cyc_drv(1, 8'h0, a, 64'h0, 0, 0, 8'h0, 16'h0, 64'h0, a_unused);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        n_chk = 0; n_pass = 0; n_fail = 0; cyc = 0; rs_cnt = 0;
        hold_m = 64'h0; err_m = 1'b0;
        rst_n = 1'b0;
        bus.comp_ren = 0; bus.comp_wen = 0; bus.comp_addr = 0; bus.comp_wdata = 0;
        bus.host_valid = 0; bus.host_write = 0; bus.host_wstrb = 0;
        bus.host_addr = 0; bus.host_wdata = 0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_comp_rdata", bus.comp_rdata, 64'h0);
        chk("rst_host_rvalid", 64'(bus.host_rvalid), 64'h0);
        chk("rst_host_rdata", bus.host_rdata, 64'h0);
        chk("rst_err", 64'(bus.err), 64'h0);
        chk("rst_host_ready", 64'(bus.host_ready), 64'h0);
        rst_n = 1'b1;
        idle(3);

        // Compute write then read, held over idle cycles
        comp_wr(16'h0010, 8'hFF, 64'h1122334455667788);
        comp_rd(16'h0010);
        idle(RDL + 5);
        chk("t1_comp_word", bus.comp_rdata, 64'h1122334455667788);

        // Byte masking
        comp_wr(16'h0020, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        comp_wr(16'h0020, 8'h0F, 64'h0);
        comp_rd(16'h0020);
        comp_wr(16'h0020, 8'h02, 64'h0000_0000_0000_AB00);
        comp_rd(16'h0020);
        idle(RDL + 1);
        chk("t2_mask_final", bus.comp_rdata, 64'hFFFF_FFFF_0000_AB00);

        // Preloads through the host port
        host_req(1, 8'hFF, 16'h0030, 64'h0000_0000_00C0_FFEE);
        for (int i = 0; i < 4; i++) host_req(1, 8'hFF, 16'(16'h0040 + i), 64'(i + 1));
        host_req(1, 8'hFF, 16'h0000, 64'h0000_0000_0000_DEAD);
        host_req(1, 8'hFF, 16'h0050, 64'h5555_5555_5555_5555);
        comp_rd(16'h0010);
        idle(RDL);

        // Arbitration: host read held off by three compute reads
        for (int i = 0; i < 3; i++) begin
            cyc_drv(1, 8'h0, 16'h0010, 64'h0, 1, 0, 8'h0, 16'h0030, 64'h0, acc);
            chk("t3_no_accept", 64'(acc), 64'h0);
        end
        host_req(0, 8'h0, 16'h0030, 64'h0);
        idle(RDL + 2);
        chk("t3_comp_kept", bus.comp_rdata, 64'h1122334455667788);

        // Back-to-back host reads
        for (int i = 0; i < 4; i++) host_req(0, 8'h0, 16'(16'h0040 + i), 64'h0);
        idle(RDL + 2);

        // Out-of-range write/read and protocol error
        host_req(1, 8'hFF, 16'(MW), 64'hFFFF_FFFF_FFFF_FFFF);
        comp_rd(16'h0000);
        host_req(0, 8'h0, 16'(MW), 64'h0);
        idle(RDL + 1);
        cyc_drv(1, 8'h01, 16'h0050, 64'h0000_0000_0000_00AA, 0, 0, 8'h0, 16'h0, 64'h0, acc);
        idle(RDL + 2);
        comp_rd(16'h0050);
        idle(RDL + 3);
        chk("t5_err_sticky", 64'(bus.err), 64'h1);

        // Reset while a host read is in flight
        host_req(0, 8'h0, 16'h0041, 64'h0);
        #3;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        hold_m = 64'h0;
        err_m  = 1'b0;
        rs_cnt = 0;
        chk("t6_rst_rvalid", 64'(bus.host_rvalid), 64'h0);
        chk("t6_rst_comp_rdata", bus.comp_rdata, 64'h0);
        chk("t6_rst_err", 64'(bus.err), 64'h0);
        idle(RDL + 2);
        rst_n = 1'b1;
        idle(3);
        comp_rd(16'h0010);
        host_req(0, 8'h0, 16'h0050, 64'h0);
        idle(RDL + 2);
        chk("t6_ram_kept", bus.comp_rdata, 64'h1122334455667788);
        chk("drain", 64'(exp_q.size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mlaccel_memory.md
Name: mlaccel_memory

Overview:
Main 64-bit data memory that responds to the compute unit's memory port: ren, byte-wen, 16-bit word address, wdata and rdata, with at most one access per cycle.
A second, lower-priority host port (valid/ready request, rvalid return) loads code, coefficients and input tensors and reads back results through the same memory.
The block arbitrates the single physical RAM port, returns read data at a fixed latency, and holds the last returned word on comp_rdata.

Parameters:
MEM_WORDS, 4096, number of 64-bit words; valid word addresses are 0..MEM_WORDS-1.
RD_LATENCY, 1, cycles from the request cycle to the cycle the read data is presented; legal range 1..4.

Ports:
clock  in  1  system clock
resetn  in  1  asynchronous active-low reset
comp_ren  in  1  compute read request this cycle
comp_wen  in  8  compute byte write enables; bit k writes wdata[8k+7:8k]
comp_addr  in  16  compute word address
comp_wdata  in  64  compute write data
comp_rdata  out  64  compute read data; holds the last returned word
host_valid  in  1  host request valid
host_ready  out  1  host request accepted this cycle (valid && ready)
host_write  in  1  1=write, 0=read
host_wstrb  in  8  host byte enables for writes
host_addr  in  16  host word address
host_wdata  in  64  host write data
host_rvalid  out  1  one-cycle pulse: host read data valid
host_rdata  out  64  host read data; valid only while host_rvalid=1
err  out  1  sticky protocol error

Behaviour:
- Reset (resetn low, asynchronous): comp_rdata=0, host_rvalid=0, host_rdata=0, err=0, return pipeline flushed.
  - RAM contents are not cleared.
  - Host reads in flight when reset asserts never produce rvalid.
- Compute priority: comp_act = comp_ren | (|comp_wen).
  - host_ready = resetn-synchronised-out && !comp_act; this is combinational from the compute inputs.
  - The compute port is never stalled.
- Host request acceptance:
  - The host request is accepted when host_valid && host_ready.
  - Host must hold its request stable until accepted.
  - host_ready is independent of host_valid.
- RAM port select: compute when comp_act, else the accepted host request, else idle.
  - Exactly one access per cycle; there is no read/write collision inside the block.
- Writes: byte-masked; only bytes with an enable bit set change. Effect is visible to any read issued in the next cycle or later.
- Compute read, request in cycle N:
  - comp_rdata updates to mem[comp_addr] at the clock edge ending cycle N+RD_LATENCY-1, so it is valid throughout cycle N+RD_LATENCY.
  - It then holds that value until the next compute read returns; host reads never disturb comp_rdata.
  - Consumers may sample any later cycle before their next read returns.
- Host read, accepted in cycle N: host_rvalid=1 and host_rdata valid in cycle N+RD_LATENCY, for exactly one cycle.
  - Back-to-back host reads are fully pipelined: one per cycle, returned in order.
- Return pipeline: RD_LATENCY-deep shift register of {valid, owner(comp/host)} tags alongside RAM data.
  - Output registering for the selected latency is implemented inside the pipeline.
- Out-of-range address (addr >= MEM_WORDS): writes are dropped; reads return 64'h0 with normal latency and handshake.
- Protocol error: comp_ren && |comp_wen in the same cycle sets err (sticky until reset).
  - The write is performed, and the read also returns data at normal latency.
- Width rule: addresses are zero-extended 16-bit words.
  - Byte addressing and odd-byte alignment are the compute unit's responsibility; this block sees word addresses only.

Decomposition:
- Shared package (mlaccel_pkg):
  - MLACCEL_WORD_W=64, MLACCEL_ADDR_W=16, MLACCEL_STRB_W=8
  - owner enum {OWN_COMP, OWN_HOST}
- Sub-module mlaccel_memory_ram: single-port, synchronous-read, byte-write-enabled array of MEM_WORDS x 64.
  - Maps to block RAM.
  - Contains no arbitration.
- The top level holds arbitration, the tag pipeline, hold registers and the error flag.

Test Plan:
- Compute write then read: comp_wen=8'hFF, addr 0x0010, wdata 0x1122334455667788; next cycle comp_ren addr 0x0010 -> comp_rdata=0x1122334455667788 at cycle +RD_LATENCY and held for 5 idle cycles.
- Byte masking: prefill 0x0020 with all-ones; comp_wen=8'h0F, wdata 0 -> read returns 0xFFFFFFFF00000000; then comp_wen=8'h02, wdata 0x0000_0000_0000_AB00 -> 0xFFFFFFFF0000AB00.
- Arbitration: host_valid read of 0x0030 held while compute issues reads on 3 consecutive cycles -> host_ready=0 for those 3 cycles, accepted on cycle 4, host_rvalid one pulse RD_LATENCY later.
  - comp_rdata still shows the compute word.
- Host pipelining: 4 back-to-back host reads of 0x40..0x43 preloaded with 1..4 -> host_rvalid high 4 consecutive cycles, data 1,2,3,4 in order.
- Out-of-range and error: host write to MEM_WORDS -> no change anywhere; host read of MEM_WORDS -> rdata 0 with rvalid; comp_ren && comp_wen=8'h01 -> err=1 and stays set.
- Reset mid-flight: accept host read, drop resetn the next cycle (asynchronously, mid-cycle) -> host_rvalid never asserts, comp_rdata=0, err=0; RAM word previously written still reads back after reset.
